// File: rtl/aes_stream_ctrl_if.sv
// Stream-side bundle of aes_stream_ctrl: key input, data-block input and result output,
// each a valid/ready handshake. The master drives offers, the slave (controller) answers.
interface aes_stream_ctrl_if #(
  parameter int KEY_W = 128,
  parameter int BLK_W = 128
);
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_data;
  logic             s_valid;
  logic             s_ready;
  logic [BLK_W-1:0] s_data;
  logic             s_decrypt;
  logic             m_valid;
  logic             m_ready;
  logic [BLK_W-1:0] m_data;

  modport master (
    output key_valid, key_data, s_valid, s_data, s_decrypt, m_ready,
    input  key_ready, s_ready, m_valid, m_data
  );

  modport slave (
    input  key_valid, key_data, s_valid, s_data, s_decrypt, m_ready,
    output key_ready, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// Streaming initiator for the AES core command port: key expand / encrypt / decrypt, results
// buffered in a DEPTH-entry FIFO. Define AES_STREAM_CNT_EN to enable the blk_cnt counter.
package aes_stream_pkg;
  localparam int NK    = 4;
  localparam int NB    = 4;
  localparam int KEY_W = 32 * NK;
  localparam int BLK_W = 32 * NB;

  typedef enum logic [1:0] {
    FUNC_NONE   = 2'd0,
    FUNC_KEYEXP = 2'd1,
    FUNC_ENC    = 2'd2,
    FUNC_DEC    = 2'd3
  } aes_func_e;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [BLK_W-1:0] data;
    aes_func_e        func;
    logic             enable;
  } aes_in_type;

  typedef struct packed {
    logic             ready;
    logic [BLK_W-1:0] result;
  } aes_out_type;
endpackage

module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  aes_stream_ctrl_if.slave bus,
  output logic             key_loaded,
  output logic             busy,
  output logic [31:0]      blk_cnt,
  output aes_in_type       aes_in,
  input  aes_out_type      aes_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_REQ,
    S_KEY_WAIT,
    S_DAT_REQ,
    S_DAT_WAIT
  } state_e;

  state_e           r_state;
  state_e           w_next;
  aes_in_type       r_aes_in;
  logic             r_key_loaded;
  logic [AW:0]      r_fifo_cnt;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [BLK_W-1:0] r_mem [DEPTH];

  logic w_idle, w_m_valid, w_s_ready, w_key_acc, w_blk_acc, w_push, w_pop;

  assign w_idle    = (r_state == S_IDLE);
  assign w_m_valid = (r_fifo_cnt != '0);
  // A pending key offer blocks data so a new key is never overtaken by a block.
  assign w_s_ready = w_idle & r_key_loaded & ~bus.key_valid & (r_fifo_cnt < FULL_CNT);
  assign w_key_acc = w_idle & bus.key_valid;
  assign w_blk_acc = w_s_ready & bus.s_valid;
  assign w_push    = (r_state == S_DAT_WAIT) & aes_out.ready;
  assign w_pop     = w_m_valid & bus.m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_key_acc)      w_next = S_KEY_REQ;
        else if (w_blk_acc) w_next = S_DAT_REQ;
      end
      S_KEY_REQ:  w_next = S_KEY_WAIT;
      S_KEY_WAIT: if (aes_out.ready) w_next = S_IDLE;
      S_DAT_REQ:  w_next = S_DAT_WAIT;
      S_DAT_WAIT: if (aes_out.ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.key_ready = w_idle;
    bus.s_ready   = w_s_ready;
    bus.m_valid   = w_m_valid;
    bus.m_data    = w_m_valid ? r_mem[r_rd_ptr] : '0;
    busy          = ~w_idle;
    key_loaded    = r_key_loaded;
    aes_in        = r_aes_in;
  end

  // Enable is registered from the next state, so it is high for exactly the *_REQ cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aes_in     <= '0;
      r_key_loaded <= 1'b0;
    end else begin
      r_aes_in.enable <= (w_next == S_KEY_REQ) || (w_next == S_DAT_REQ);
      if (w_key_acc) begin
        r_aes_in.key  <= bus.key_data;
        r_aes_in.func <= FUNC_KEYEXP;
        r_key_loaded  <= 1'b0;
      end else if (w_blk_acc) begin
        r_aes_in.data <= bus.s_data;
        r_aes_in.func <= bus.s_decrypt ? FUNC_DEC : FUNC_ENC;
      end
      if ((r_state == S_KEY_WAIT) && aes_out.ready) r_key_loaded <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW + 1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW + 1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // NOTE: storage is not reset; the count gates m_data, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= aes_out.result;
  end

`ifdef AES_STREAM_CNT_EN
  logic [31:0] r_blk_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_blk_cnt <= '0;
    else if (w_push) r_blk_cnt <= r_blk_cnt + 32'd1;
  end

  assign blk_cnt = r_blk_cnt;
`else
  assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: a stand-in AES core with random latency, a transaction-level
// reference model (outstanding flag, expected-result queue) and a per-cycle compare process.
module tb_aes_stream_ctrl;
  import aes_stream_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_loaded, busy;
  logic [31:0] blk_cnt;
  aes_in_type  aes_in;
  aes_out_type aes_out;

  aes_stream_ctrl_if #(.KEY_W(KEY_W), .BLK_W(BLK_W)) bus ();

  aes_stream_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .key_loaded (key_loaded),
    .busy       (busy),
    .blk_cnt    (blk_cnt),
    .aes_in     (aes_in),
    .aes_out    (aes_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behaviour of the stand-in core: FIPS-197 C.1 pair, otherwise a cheap distinct mapping per func.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d,
                                           input logic [1:0] f);
    if (k == FIPS_KEY && f == 2'd2 && d == FIPS_PT) return FIPS_CT;
    if (k == FIPS_KEY && f == 2'd3 && d == FIPS_CT) return FIPS_PT;
    if (f == 2'd2) return d ^ k ^ 128'h5a5a5a5a_a5a5a5a5_5a5a5a5a_a5a5a5a5;
    return {d[63:0], d[127:64]} ^ k;
  endfunction

  // Reference model state, advanced once per rising edge.
  bit           m_out = 1'b0;
  bit           m_req = 1'b0;
  bit           m_is_key = 1'b0;
  bit           m_kl = 1'b0;
  bit           m_blk_acc = 1'b0;
  int           m_occ = 0;
  logic [1:0]   m_func = '0;
  logic [127:0] m_key = '0;
  logic [127:0] m_dat = '0;
  logic [31:0]  m_cnt = '0;
  logic [127:0] exp_q[$];

  initial forever begin
    bit resp, pop, kacc, bacc;
    @(posedge clk);
    m_blk_acc = 1'b0;
    if (!rst) begin
      m_out = 1'b0; m_req = 1'b0; m_kl = 1'b0; m_occ = 0; m_cnt = '0; m_func = '0;
      exp_q.delete();
    end else begin
      resp = aes_out.ready && m_out && !m_req;
      pop  = bus.m_ready && (m_occ > 0);
      kacc = !m_out && bus.key_valid;
      bacc = !m_out && m_kl && !bus.key_valid && bus.s_valid && (m_occ < DEPTH);
      m_req = 1'b0;
      if (resp) begin
        m_out = 1'b0;
        if (m_is_key) m_kl = 1'b1;
        else begin m_occ++; m_cnt++; end
      end
      if (pop) begin
        m_occ--;
        void'(exp_q.pop_front());
      end
      if (kacc) begin
        m_out = 1'b1; m_req = 1'b1; m_is_key = 1'b1; m_kl = 1'b0;
        m_func = 2'd1; m_key = bus.key_data;
      end else if (bacc) begin
        m_out = 1'b1; m_req = 1'b1; m_is_key = 1'b0; m_blk_acc = 1'b1;
        m_func = bus.s_decrypt ? 2'd3 : 2'd2; m_dat = bus.s_data;
        exp_q.push_back(core_fn(m_key, bus.s_data, m_func));
      end
    end
  end

  // Stand-in core: responds 1..4 cycles after enable, sometimes pulses ready while idle.
  bit           st_pend = 1'b0;
  int           st_lat = 0;
  int           en_seen = 0;
  logic [1:0]   st_func = '0;
  logic [127:0] st_key = '0;
  logic [127:0] st_data = '0;

  initial begin
    aes_out = '0;
    forever begin
      @(posedge clk);
      #1;
      aes_out.ready  = 1'b0;
      aes_out.result = rnd128();
      if (!rst) st_pend = 1'b0;
      else if (aes_in.enable) begin
        en_seen++;
        st_pend = 1'b1;
        st_lat  = $urandom_range(0, 3);
        st_func = aes_in.func;
        st_data = aes_in.data;
        if (aes_in.func == FUNC_KEYEXP) st_key = aes_in.key;
      end else if (st_pend) begin
        if (st_lat == 0) begin
          aes_out.ready = 1'b1;
          if (st_func != 2'd1) aes_out.result = core_fn(st_key, st_data, st_func);
          st_pend = 1'b0;
        end else st_lat--;
      end else if (!m_out && $urandom_range(0, 7) == 0) aes_out.ready = 1'b1;
    end
  end

  initial forever begin
    logic [31:0] exp_cnt;
    @(negedge clk);
    if (rst && cmp_en) begin
`ifdef AES_STREAM_CNT_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = '0;
`endif
      check("key_ready", bus.key_ready, !m_out);
      check("s_ready", bus.s_ready, !m_out && m_kl && !bus.key_valid && (m_occ < DEPTH));
      check("busy", busy, m_out);
      check("key_loaded", key_loaded, m_kl);
      check("m_valid", bus.m_valid, m_occ > 0);
      check("enable", aes_in.enable, m_req);
      check("blk_cnt", blk_cnt, exp_cnt);
      if (m_out) check("func", aes_in.func, m_func);
      if (m_out && m_is_key) check("cmd_key", aes_in.key, m_key);
      if (m_out && !m_is_key) check("cmd_data", aes_in.data, m_dat);
      if (m_occ > 0) check("m_data", bus.m_data, exp_q[0]);
    end
  end

  task automatic send_block(input logic [127:0] d, input logic dec, output bit ok);
    bus.s_data = d; bus.s_decrypt = dec; bus.s_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      ok = m_blk_acc;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(output bit ok);
    ok = bus.m_valid;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      ok = bus.m_valid;
    end
  endtask

  task automatic wait_quiet(input int want_occ, output bit ok);
    ok = !m_out && (m_occ == want_occ);
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      ok = !m_out && (m_occ == want_occ);
    end
  endtask

  task automatic pop_one();
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    logic [127:0] b0, b1, b2;
    logic [31:0] cnt_one, cnt_two;
`ifdef AES_STREAM_CNT_EN
    cnt_one = 32'd1; cnt_two = 32'd2;
`else
    cnt_one = 32'd0; cnt_two = 32'd0;
`endif
    bus.key_valid = 1'b0; bus.key_data = '0; bus.s_valid = 1'b0; bus.s_data = '0;
    bus.s_decrypt = 1'b0; bus.m_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_key_loaded", key_loaded, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_data", bus.m_data, '0);
    check("rst_aes_in", aes_in, '0);
    check("rst_blk_cnt", blk_cnt, '0);
    check("rst_key_ready", bus.key_ready, 1'b1);
    check("rst_s_ready", bus.s_ready, 1'b0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Data offered before any key is never accepted.
    bus.s_valid = 1'b1; bus.s_data = FIPS_PT;
    repeat (6) @(posedge clk);
    #1;
    check("nokey_enable_seen", en_seen, 0);
    check("nokey_busy", busy, 1'b0);
    check("nokey_s_ready", bus.s_ready, 1'b0);
    bus.s_valid = 1'b0;

    // Key expansion command.
    bus.key_valid = 1'b1; bus.key_data = FIPS_KEY;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    check("key_enable", aes_in.enable, 1'b1);
    check("key_func", aes_in.func, 2'd1);
    check("key_value", aes_in.key, FIPS_KEY);
    @(posedge clk); #1;
    check("key_enable_one_cycle", aes_in.enable, 1'b0);
    ok = key_loaded;
    for (int i = 0; i < 40 && !ok; i++) begin @(posedge clk); #1; ok = key_loaded; end
    check("key_loaded_timeout", ok, 1'b1);

    // FIPS-197 C.1 encrypt then decrypt.
    send_block(FIPS_PT, 1'b0, ok);
    check("enc_accept_timeout", ok, 1'b1);
    wait_mvalid(ok);
    check("enc_result_timeout", ok, 1'b1);
    check("enc_result", bus.m_data, FIPS_CT);
    check("enc_blk_cnt", blk_cnt, cnt_one);
    pop_one();
    send_block(FIPS_CT, 1'b1, ok);
    check("dec_accept_timeout", ok, 1'b1);
    wait_mvalid(ok);
    check("dec_result_timeout", ok, 1'b1);
    check("dec_result", bus.m_data, FIPS_PT);
    check("dec_blk_cnt", blk_cnt, cnt_two);
    pop_one();

    // Back-pressure: FIFO fills at DEPTH, third block waits for a pop.
    b0 = rnd128(); b1 = rnd128(); b2 = rnd128();
    send_block(b0, 1'b0, ok);
    check("bp_b0_timeout", ok, 1'b1);
    send_block(b1, 1'b1, ok);
    check("bp_b1_timeout", ok, 1'b1);
    bus.s_data = b2; bus.s_decrypt = 1'b0; bus.s_valid = 1'b1;
    wait_quiet(DEPTH, ok);
    check("bp_full_timeout", ok, 1'b1);
    acc = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; acc += int'(m_blk_acc); end
    check("bp_full_s_ready", bus.s_ready, 1'b0);
    check("bp_full_no_accept", acc, 0);
    check("bp_head", bus.m_data, core_fn(FIPS_KEY, b0, 2'd2));
    pop_one();
    check("bp_second", bus.m_data, core_fn(FIPS_KEY, b1, 2'd3));
    ok = m_blk_acc;
    for (int i = 0; i < 10 && !ok; i++) begin @(posedge clk); #1; ok = m_blk_acc; end
    check("bp_b2_accept_timeout", ok, 1'b1);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    wait_quiet(0, ok);
    check("bp_drain_timeout", ok, 1'b1);

    // Randomised traffic with occasional key changes.
    for (int i = 0; i < 600; i++) begin
      bus.key_valid = ($urandom_range(0, 40) == 0);
      bus.key_data  = $urandom_range(0, 1) ? FIPS_KEY : rnd128();
      bus.s_valid   = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       bus.s_data = FIPS_PT;
        1:       bus.s_data = FIPS_CT;
        default: bus.s_data = rnd128();
      endcase
      bus.s_decrypt = $urandom_range(0, 1);
      bus.m_ready   = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    bus.key_valid = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    wait_quiet(0, ok);
    check("rand_drain_timeout", ok, 1'b1);

    // Reset while a data command is in flight and one result is buffered.
    bus.m_ready = 1'b0;
    send_block(rnd128(), 1'b0, ok);
    check("rst_pre_accept_timeout", ok, 1'b1);
    wait_mvalid(ok);
    check("rst_pre_result_timeout", ok, 1'b1);
    send_block(rnd128(), 1'b1, ok);
    check("rst_inflight_timeout", ok, 1'b1);
    @(posedge clk); #1;
    check("rst_inflight_busy", busy, 1'b1);
    rst = 1'b0;
    cmp_en = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_key_loaded", key_loaded, 1'b0);
    check("arst_m_valid", bus.m_valid, 1'b0);
    check("arst_m_data", bus.m_data, '0);
    check("arst_aes_in", aes_in, '0);
    check("arst_blk_cnt", blk_cnt, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cmp_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_m_valid", bus.m_valid, 1'b0);
    check("post_rst_key_loaded", key_loaded, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
